// File: rtl/pixel_chunker_if.sv
// Pixel payload type and the chunk stream interface driven by pixel_chunker.
//   pixel_pkg::pixel_t : {red, grn, blu}, 8 bits each
//   axis_if            : data[DIM][DIM] window of pixel_t, vld, rdy
//     master modport   : drives data/vld, samples rdy
//     slave modport    : samples data/vld, drives rdy
package pixel_pkg;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } pixel_t;

endpackage

interface axis_if #(
    parameter int unsigned DIM = 3
);
    // data[r][c]: r=0 oldest line, c=DIM-1 newest column
    pixel_pkg::pixel_t [DIM-1:0][DIM-1:0] data;
    logic                                 vld;
    logic                                 rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);

endinterface

// File: rtl/pixel_chunker.sv
// pixel_chunker: builds DIM x DIM pixel windows from a raster-order pixel stream
// and emits one window per accepted pixel once a full (unpadded) window exists.
// Optional feature macro: PIXEL_CHUNKER_SOF_EN (adds sof_i, forces position (0,0)).
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   pix_i         : input pixel (pixel_pkg::pixel_t)
//   pix_vld_i     : pix_i valid
//   pix_rdy_o     : pixel accepted this cycle when high with pix_vld_i (comb)
//   sof_i         : start of frame qualifier (PIXEL_CHUNKER_SOF_EN only)
//   frame_done_o  : one-cycle pulse after the last pixel of a frame is accepted
//   axis_o        : chunk output stream (axis_if master)
module pixel_chunker #(
    parameter int unsigned DIM   = 3,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  pixel_pkg::pixel_t pix_i,
    input  logic              pix_vld_i,
    output logic              pix_rdy_o,
`ifdef PIXEL_CHUNKER_SOF_EN
    input  logic              sof_i,
`endif
    output logic              frame_done_o,
    axis_if.master            axis_o
);
    import pixel_pkg::*;

    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam int unsigned NLB = DIM - 1;

    typedef pixel_t [DIM-1:0][DIM-1:0] win_t;

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_vld;
    logic          r_done;
    win_t          r_win;
    win_t          r_data;
    pixel_t        r_lb [NLB][IMG_W];

    logic          w_acc;
    logic          w_sof;
    logic          w_emit;
    logic          w_col_last;
    logic          w_row_last;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    win_t          w_win_nxt;

    assign pix_rdy_o = ~r_vld | axis_o.rdy;
    assign w_acc     = pix_vld_i & pix_rdy_o;

`ifdef PIXEL_CHUNKER_SOF_EN
    assign w_sof = sof_i;
`else
    assign w_sof = 1'b0;
`endif

    // Position of the pixel being offered; SOF overrides the counters
    assign w_col      = w_sof ? '0 : r_col;
    assign w_row      = w_sof ? '0 : r_row;
    assign w_col_last = (w_col == CW'(IMG_W - 1));
    assign w_row_last = (w_row == RW'(IMG_H - 1));
    assign w_emit     = w_acc & (w_row >= RW'(DIM - 1)) & (w_col >= CW'(DIM - 1));

    // Window after shifting in the new column: line buffers oldest..newest, then pix_i
    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < int'(DIM); r++) begin
            for (int c = 0; c < int'(DIM) - 1; c++) begin
                w_win_nxt[r][c] = r_win[r][c+1];
            end
        end
        for (int r = 0; r < int'(NLB); r++) begin
            w_win_nxt[r][DIM-1] = r_lb[r][w_col];
        end
        w_win_nxt[DIM-1][DIM-1] = pix_i;
    end

    // Line buffer chain (read-before-write at w_col) and shift window; not reset
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int k = 0; k < int'(NLB) - 1; k++) begin
                r_lb[k][w_col] <= r_lb[k+1][w_col];
            end
            r_lb[NLB-1][w_col] <= pix_i;
            r_win              <= w_win_nxt;
        end
    end

    // Output data register; stable while a chunk waits since no acc can occur
    always_ff @(posedge clk) begin
        if (w_emit) begin
            r_data <= w_win_nxt;
        end
    end

    // Position counters, output valid and frame-done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_vld  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_acc & w_col_last & w_row_last;
            if (w_acc) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
            if (w_emit) begin
                r_vld <= 1'b1;
            end else if (axis_o.rdy) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign axis_o.vld   = r_vld;
    assign axis_o.data  = r_data;
    assign frame_done_o = r_done;

endmodule

// File: tb/tb_pixel_chunker.sv
// Directed bench for pixel_chunker with DIM=3, IMG_W=5, IMG_H=4; pixel value is
// the frame raster index n on all channels.
module tb_pixel_chunker;
    import pixel_pkg::*;

    localparam int unsigned DIM   = 3;
    localparam int unsigned IMG_W = 5;
    localparam int unsigned IMG_H = 4;

    logic   clk = 1'b0;
    logic   rst;
    pixel_t pix_i;
    logic   pix_vld_i;
    logic   pix_rdy_o;
    logic   frame_done_o;
`ifdef PIXEL_CHUNKER_SOF_EN
    logic   sof_i;
`endif

    axis_if #(.DIM(DIM)) axis_o_if ();

    pixel_chunker #(.DIM(DIM), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk          (clk),
        .rst          (rst),
        .pix_i        (pix_i),
        .pix_vld_i    (pix_vld_i),
        .pix_rdy_o    (pix_rdy_o),
`ifdef PIXEL_CHUNKER_SOF_EN
        .sof_i        (sof_i),
`endif
        .frame_done_o (frame_done_o),
        .axis_o       (axis_o_if)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int chunk_cnt = 0;
    int done_cnt  = 0;
    int tb_row    = 0;
    int tb_col    = 0;
    bit rand_mode = 1'b0;
    logic [215:0] exp_q [$];

    task automatic check(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Window whose newest pixel sits at (r,c): element [i][j] = pixel (r-2+i, c-2+j)
    function automatic logic [215:0] exp_win(input int r, input int c);
        pixel_t [2:0][2:0] w;
        int v;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v = (r - 2 + i) * 5 + (c - 2 + j);
                w[i][j] = '{v[7:0], v[7:0], v[7:0]};
            end
        end
        return w;
    endfunction

    // One clock: sample at negedge, advance model after the edge, return at posedge+1
    task automatic step(output bit acc);
        @(negedge clk);
        acc = pix_vld_i && pix_rdy_o && !rst;
        if (axis_o_if.vld && axis_o_if.rdy && !rst) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL chunk_extra observed=unexpected chunk expected=none");
            end
            if (exp_q.size() != 0) begin
                check("chunk_data", axis_o_if.data, exp_q.pop_front());
                chunk_cnt++;
            end
        end
        if (frame_done_o) done_cnt++;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            tb_row = 0;
            tb_col = 0;
        end else if (acc) begin
            if (tb_row >= 2 && tb_col >= 2) exp_q.push_back(exp_win(tb_row, tb_col));
            if (tb_col == 4) begin
                tb_col = 0;
                tb_row = (tb_row == 3) ? 0 : tb_row + 1;
            end else begin
                tb_col++;
            end
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) begin
            step(acc);
            if (rand_mode) axis_o_if.rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_pix(input bit sof, output int cyc);
        bit acc;
        bit got;
        int n;
        got = 1'b0;
        cyc = 0;
        if (sof) begin
            tb_row = 0;
            tb_col = 0;
        end
        n = tb_row * 5 + tb_col;
        pix_i     = '{n[7:0], n[7:0], n[7:0]};
        pix_vld_i = 1'b1;
`ifdef PIXEL_CHUNKER_SOF_EN
        sof_i     = sof;
`endif
        for (int k = 0; k < 64 && !got; k++) begin
            step(acc);
            cyc++;
            got = acc;
            if (rand_mode) axis_o_if.rdy = 1'($urandom_range(0, 1));
        end
        pix_vld_i = 1'b0;
`ifdef PIXEL_CHUNKER_SOF_EN
        sof_i     = 1'b0;
`endif
        if (!got) check("pix_accept_timeout", 216'(got), 216'(1));
    endtask

    task automatic send_n(input int n);
        int cyc;
        for (int k = 0; k < n; k++) send_pix(1'b0, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst           = 1'b1;
        pix_i         = '0;
        pix_vld_i     = 1'b0;
        axis_o_if.rdy = 1'b1;
`ifdef PIXEL_CHUNKER_SOF_EN
        sof_i         = 1'b0;
`endif
        idle(3);
        rst = 1'b0;
        check("reset_vld", 216'(axis_o_if.vld), 216'(0));
        check("reset_frame_done", 216'(frame_done_o), 216'(0));
        check("reset_pix_rdy", 216'(pix_rdy_o), 216'(1));

        // Frame A: free-flowing
        send_n(12);
        check("a_no_vld_before_12", 216'(axis_o_if.vld), 216'(0));
        send_n(1);
        check("a_first_vld", 216'(axis_o_if.vld), 216'(1));
        check("a_first_data", axis_o_if.data, exp_win(2, 2));
        send_n(7);
        check("a_frame_done", 216'(frame_done_o), 216'(1));
        idle(1);
        check("a_frame_done_clear", 216'(frame_done_o), 216'(0));
        check("a_vld_drop", 216'(axis_o_if.vld), 216'(0));
        check("a_chunks", 216'(chunk_cnt), 216'(6));
        check("a_last_popped", 216'(exp_q.size()), 216'(0));

        // Frame B: back-pressure from the first chunk
        send_n(13);
        axis_o_if.rdy = 1'b0;
        pix_i     = '{8'd13, 8'd13, 8'd13};
        pix_vld_i = 1'b1;
        idle(3);
        check("b_hold_vld", 216'(axis_o_if.vld), 216'(1));
        check("b_hold_pix_rdy", 216'(pix_rdy_o), 216'(0));
        check("b_hold_data", axis_o_if.data, exp_win(2, 2));
        axis_o_if.rdy = 1'b1;
        send_pix(1'b0, cyc);
        check("b_release_cycles", 216'(cyc), 216'(1));
        check("b_b2b_vld", 216'(axis_o_if.vld), 216'(1));
        check("b_b2b_data", axis_o_if.data, exp_win(2, 3));
        send_n(6);
        idle(2);
        check("b_chunks", 216'(chunk_cnt), 216'(12));
        check("b_done_cnt", 216'(done_cnt), 216'(2));

        // Frame C: reset while a chunk is pending
        send_n(15);
        axis_o_if.rdy = 1'b0;
        check("c_pending_vld", 216'(axis_o_if.vld), 216'(1));
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("c_reset_vld", 216'(axis_o_if.vld), 216'(0));
        check("c_reset_pix_rdy", 216'(pix_rdy_o), 216'(1));
        axis_o_if.rdy = 1'b1;

        // Frame D: restart from (0,0)
        send_n(12);
        check("d_no_vld_before_13", 216'(axis_o_if.vld), 216'(0));
        send_n(1);
        check("d_first_vld", 216'(axis_o_if.vld), 216'(1));
        check("d_first_data", axis_o_if.data, exp_win(2, 2));
        send_n(7);
        idle(2);
        check("d_chunks", 216'(chunk_cnt), 216'(20));
        check("d_done_cnt", 216'(done_cnt), 216'(3));

        // Three frames with random input gaps and output stalls
        rand_mode = 1'b1;
        for (int p = 0; p < 60; p++) begin
            idle(int'($urandom_range(0, 2)));
            send_n(1);
        end
        rand_mode     = 1'b0;
        axis_o_if.rdy = 1'b1;
        idle(4);
        check("rand_chunks", 216'(chunk_cnt), 216'(38));
        check("rand_queue_empty", 216'(exp_q.size()), 216'(0));
        check("rand_done_cnt", 216'(done_cnt), 216'(6));

`ifdef PIXEL_CHUNKER_SOF_EN
        // SOF on pixel 7 restarts the position at (0,0)
        send_n(7);
        send_pix(1'b1, cyc);
        send_n(11);
        check("sof_no_vld_before_13", 216'(axis_o_if.vld), 216'(0));
        send_n(1);
        check("sof_first_vld", 216'(axis_o_if.vld), 216'(1));
        check("sof_first_data", axis_o_if.data, exp_win(2, 2));
        send_n(7);
        idle(2);
        check("sof_chunks", 216'(chunk_cnt), 216'(44));
        check("sof_done_cnt", 216'(done_cnt), 216'(7));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
